// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared phase encoding, widths and phase helpers for traffic_light_ctrl
package traffic_light_pkg;

    localparam int CD_W  = 4;
    localparam int ROW_W = 3;

    typedef enum logic [1:0] {
        ST_GO   = 2'd0,
        ST_WARN = 2'd1,
        ST_STOP = 2'd2,
        ST_BAD  = 2'd3
    } phase_t;

    function automatic phase_t next_phase(input phase_t cur);
        case (cur)
            ST_STOP: next_phase = ST_GO;
            ST_GO:   next_phase = ST_WARN;
            default: next_phase = ST_STOP;
        endcase
    endfunction

    function automatic logic [CD_W-1:0] phase_time(
        input phase_t          ph,
        input logic [CD_W-1:0] go_time,
        input logic [CD_W-1:0] warn_time,
        input logic [CD_W-1:0] stop_time
    );
        case (ph)
            ST_GO:   phase_time = go_time;
            ST_WARN: phase_time = warn_time;
            default: phase_time = stop_time;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_if.sv
// rtl/traffic_light_if.sv - control inputs and display outputs of traffic_light_ctrl
interface traffic_light_if;
    import traffic_light_pkg::*;

    logic             hold;
    logic             ped_req;
    logic [1:0]       state;
    logic [ROW_W-1:0] row_cnt;
    logic [CD_W-1:0]  count_down;

    modport master (input hold, ped_req, output state, row_cnt, count_down);
    modport slave  (output hold, ped_req, input state, row_cnt, count_down);
endinterface

// File: rtl/traffic_light_tick_divider.sv
// rtl/traffic_light_tick_divider.sv - enable-gated prescaler producing a one-cycle tick every DIV counts
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // A disabled prescaler keeps its count so a released hold resumes mid-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);
endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - phase/count-down sequencer and row scan for the light display (optional TL_PED_REQ_EN)
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int              SEC_DIV   = 50_000_000,
    parameter int              SCAN_DIV  = 50_000,
    parameter logic [CD_W-1:0] GO_TIME   = 4'd15,
    parameter logic [CD_W-1:0] WARN_TIME = 4'd3,
    parameter logic [CD_W-1:0] STOP_TIME = 4'd10,
    parameter logic [CD_W-1:0] PED_SHORT = 4'd3
) (
    input  logic             clk,
    input  logic             rst_n,
    traffic_light_if.master  disp
);
    phase_t           state_q, state_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic [ROW_W-1:0] row_q;
    logic             sec_tick;
    logic             scan_tick;
    logic             ped_edge;

    tick_divider #(.DIV(SEC_DIV)) u_sec_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~disp.hold),
        .tick  (sec_tick)
    );

    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .tick  (scan_tick)
    );

`ifdef TL_PED_REQ_EN
    logic ped_meta, ped_sync, ped_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_meta <= 1'b0;
            ped_sync <= 1'b0;
            ped_prev <= 1'b0;
        end else begin
            ped_meta <= disp.ped_req;
            ped_sync <= ped_meta;
            ped_prev <= ped_sync;
        end
    end

    assign ped_edge = ped_sync & ~ped_prev;
`else
    logic unused_ped_req;
    assign unused_ped_req = disp.ped_req;
    assign ped_edge       = 1'b0;
`endif

    // Priority: upset recovery, then pedestrian shortening, then the 1 s step.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        if (state_q == ST_BAD) begin
            state_d = ST_STOP;
            cd_d    = STOP_TIME;
        end else if (ped_edge && !disp.hold && state_q == ST_GO && cd_q > PED_SHORT) begin
            cd_d = PED_SHORT;
        end else if (sec_tick) begin
            if (cd_q == '0) begin
                state_d = next_phase(state_q);
                cd_d    = phase_time(state_d, GO_TIME, WARN_TIME, STOP_TIME);
            end else begin
                cd_d = cd_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            cd_q    <= STOP_TIME;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else if (scan_tick) begin
            row_q <= row_q + 1'b1;
        end
    end

    assign disp.state      = state_q;
    assign disp.count_down = cd_q;
    assign disp.row_cnt    = row_q;
endmodule
